// File: rtl/qproject_if.sv
// Valid/ready stream interface carrying a W-bit payload (data plus any eot bits).
// producer/consumer are the modports used by qproject; master/slave are aliases of them.
interface dti_s_if #(
    parameter int W = 8
);
    logic         valid;
    logic         ready;
    logic [W-1:0] data;

    modport producer (output valid, output data, input ready);
    modport consumer (input valid, input data, output ready);
    modport master   (output valid, output data, input ready);
    modport slave    (input valid, input data, output ready);
endinterface

// File: rtl/qproject.sv
// Queue projector: drops outer eot levels (MODE=0) or merges inner levels (MODE=1),
// then registers the result through a 2-entry skid buffer. QPROJECT_CNT_EN adds a beat counter.
module qproject #(
    parameter int TDIN     = 16,
    parameter int DIN_LVL  = 2,
    parameter int DOUT_LVL = 1,
    parameter int MODE     = 0,
    parameter int CNT_W    = 16
) (
    input  logic       clk,
    input  logic       rst,
    dti_s_if.consumer  din,
    dti_s_if.producer  dout
`ifdef QPROJECT_CNT_EN
    ,
    dti_s_if.producer  cnt
`endif
);
    localparam int TOUT     = TDIN + DOUT_LVL;
    // Lowest din eot bit that survives projection
    localparam int EOT_BASE = TDIN + ((MODE == 1) ? (DIN_LVL - DOUT_LVL) : 0);

    logic [TOUT-1:0] w_proj;
    logic            w_blk;
    logic            w_in_rdy;
    logic            w_out_vld;
    logic            w_push;
    logic            w_pop;

    logic [1:0]      r_occ;
    logic [TOUT-1:0] r_head;
    logic [TOUT-1:0] r_tail;

    assign w_proj[TDIN-1:0] = din.data[TDIN-1:0];

    generate
        for (genvar gi = 0; gi < DOUT_LVL; gi++) begin : g_eot
            assign w_proj[TDIN+gi] = din.data[EOT_BASE+gi];
        end
    endgenerate

    assign w_in_rdy  = !rst && (r_occ != 2'd2) && !w_blk;
    assign w_out_vld = !rst && (r_occ != 2'd0);
    assign w_push    = din.valid && w_in_rdy;
    assign w_pop     = w_out_vld && dout.ready;

    assign din.ready  = w_in_rdy;
    assign dout.valid = w_out_vld;
    assign dout.data  = r_head;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_occ <= 2'd0;
        end else if (w_push && !w_pop) begin
            r_occ <= r_occ + 2'd1;
        end else if (!w_push && w_pop) begin
            r_occ <= r_occ - 2'd1;
        end
    end

    // Head always holds the oldest beat; push with a full buffer cannot happen.
    always_ff @(posedge clk) begin
        if (w_pop) begin
            if (r_occ == 2'd2) begin
                r_head <= r_tail;
            end else if (w_push) begin
                r_head <= w_proj;
            end
        end else if (w_push) begin
            if (r_occ == 2'd0) begin
                r_head <= w_proj;
            end else begin
                r_tail <= w_proj;
            end
        end
    end

`ifdef QPROJECT_CNT_EN
    logic [CNT_W-1:0] r_beats;
    logic [CNT_W-1:0] r_cnt_data;
    logic             r_cnt_vld;
    logic [CNT_W-1:0] w_beats_inc;
    logic             w_last;

    assign w_last      = &din.data[TDIN+DIN_LVL-1:TDIN];
    assign w_beats_inc = (&r_beats) ? r_beats : (r_beats + 1'b1);
    // Stall input while a count is unconsumed so no count is overwritten
    assign w_blk       = r_cnt_vld && !cnt.ready;
    assign cnt.valid   = r_cnt_vld;
    assign cnt.data    = r_cnt_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_beats    <= '0;
            r_cnt_data <= '0;
            r_cnt_vld  <= 1'b0;
        end else begin
            if (r_cnt_vld && cnt.ready) begin
                r_cnt_vld <= 1'b0;
            end
            if (w_push) begin
                if (w_last) begin
                    r_cnt_data <= w_beats_inc;
                    r_cnt_vld  <= 1'b1;
                    r_beats    <= '0;
                end else begin
                    r_beats <= w_beats_inc;
                end
            end
        end
    end
`else
    assign w_blk = 1'b0;
`endif

endmodule

// File: doc/qproject.md
# qproject

Parametrised queue projector with a registered output stage. It converts a DIN_LVL-level queue into a DOUT_LVL-level queue. In keep-inner mode it drops the outer end-of-transaction (eot) levels; in flatten mode it merges the inner levels. Output is registered through a 2-entry skid buffer for full throughput, so it sits between DTI stages wherever queue levels are reduced.

## Interface

**Parameters**
- TDIN, 16: width of the data field.
- DIN_LVL, 2: number of eot levels on din; must be at least 1.
- DOUT_LVL, 1: number of eot levels on dout; 0 to DIN_LVL.
- MODE, 0: projection mode. 0 is keep-inner, 1 is flatten.
- CNT_W, 16: beat-counter width; used only with QPROJECT_CNT_EN.

**Ports**
- clk  input  1  clock.
- rst  input  1  synchronous, active-high reset.
- din  dti_s_if.consumer  TDIN+DIN_LVL  input queue; data in bits [TDIN-1:0], eot in bits [TDIN+DIN_LVL-1:TDIN].
- dout  dti_s_if.producer  TDIN+DOUT_LVL  output queue, same layout; TDIN bits when DOUT_LVL=0.
- cnt  dti_s_if.producer  CNT_W  beat count per top-level transaction; present only with QPROJECT_CNT_EN.

One clock; reset is synchronous and active-high.

## Operation

**Projection**, applied combinationally before the buffer:
- Data bits pass unchanged.
- MODE=0: out_eot = in_eot[DOUT_LVL-1:0]. Outer levels are discarded.
- MODE=1: out_eot = in_eot[DIN_LVL-1:DIN_LVL-DOUT_LVL]. The inner DIN_LVL-DOUT_LVL levels are merged.
- DOUT_LVL=0: no eot on dout in either mode.
- DOUT_LVL=DIN_LVL: identity.

**Skid buffer**
- 2-entry FIFO with occupancy cnt_q in 0..2.
- Accept on din.valid && din.ready; emit on dout.valid && dout.ready.
- din.ready = (cnt_q < 2) && !cnt_block, where cnt_block is 0 without the macro.
- din.ready must not depend combinationally on din.valid or dout.ready.
- dout.valid = (cnt_q != 0). dout.data is the head entry, driven from a register.
- Simultaneous accept and emit: cnt_q is unchanged and order is preserved.
- Accept when cnt_q=2 is impossible because din.ready is 0.
- Emit when cnt_q=0 is impossible.

**Rules**
- Ordering is strictly FIFO; no beat is dropped or duplicated.
- Once raised, dout.valid stays high and dout.data stays stable until dout.ready.
- Reset mid-operation discards all buffered beats; the held (un-popped) beats are lost.

## Timing

- **Reset values:** cnt_q=0, dout.valid=0, din.ready=0 while rst=1. din.ready=1 in the first cycle after rst falls.
- **Latency:** a beat accepted in cycle N is visible on dout in cycle N+1.
- **Throughput:** 1 beat/cycle when dout.ready stays high.
- **Backpressure:** after dout.ready falls, at most 2 further beats are accepted; din.ready then falls.
- **Recovery:** with cnt_q=2 and dout.ready high in cycle N, din.ready=1 in cycle N+1.

## Configuration

**QPROJECT_CNT_EN defined**
- A CNT_W-bit register counts accepted din beats.
- On acceptance of a beat with all DIN_LVL eot bits set:
  - the count including that beat is loaded into the cnt output register and cnt.valid is set;
  - the counter clears to 0.
- The counter saturates at 2^CNT_W-1.
- cnt.valid clears on cnt.ready.
- cnt_block = cnt.valid && !cnt.ready. This stalls din while an unconsumed count is pending, so no count is ever overwritten.
- On reset, cnt.valid=0 and the counter is 0.

**QPROJECT_CNT_EN not defined**
- The cnt port, the counter and cnt_block are absent (cnt_block is 0).
- Behaviour is otherwise identical.

## Test plan

- **Keep-inner stream:** TDIN=8, DIN_LVL=2, DOUT_LVL=1, MODE=0, dout.ready=1. Send data 1,2,3 with eot 00,01,11. Expect dout data 1,2,3 with eot 0,1,1, arriving one cycle after each accept at 1 beat/cycle.
- **Flatten stream:** same stimulus with MODE=1. Expect dout eot 0,0,1.
- **Backpressure:** hold dout.ready=0 and drive din.valid=1. Expect exactly 2 accepts, then din.ready=0. Raise dout.ready; expect din.ready=1 one cycle later and no loss or reorder across 100 random ready/valid cycles.
- **Reset mid-stream:** with 2 beats buffered, pulse rst for 1 cycle. Expect dout.valid=0 and din.ready=0 during reset, and neither buffered beat emitted afterwards.
- **DOUT_LVL=0:** DIN_LVL=1. Send data 0xA5 with eot 1. Expect an 8-bit dout of 0xA5.
- **QPROJECT_CNT_EN:**
  - Send a 5-beat transaction, last beat eot=11, with cnt.ready=0. Expect cnt=5 and cnt.valid=1.
  - Send a second transaction. Expect din to stall on its first beat until cnt.ready=1.
  - Then expect cnt=3 for a 3-beat transaction.
